core_dma_cmd_queue: RTL and testbench

//  Decouples core EX-stage DMA instructions from the PIM DMA engine. Buffers up to DEPTH commands so the

---
 rtl/core_pkg.sv | 23 ++
 rtl/core_sync_fifo.sv | 56 +++++
 rtl/core_dma_cmd_queue.sv | 131 +++++++++++++
 tb/tb_core_dma_cmd_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: DMA command bundle and command-queue FSM states.
// Default widths match the PIM DMA engine interface.
package core_pkg;

  localparam int unsigned DMA_XLEN    = 32;
  localparam int unsigned DMA_NUM_PIM = 4;
  localparam int unsigned DMA_SIZE_W  = 13;

  typedef struct packed {
    logic [2:0]             funct3;
    logic [DMA_NUM_PIM-1:0] sel_pim;
    logic [DMA_SIZE_W-1:0]  size;
    logic [DMA_XLEN-1:0]    addr;
  } dma_cmd_t;

  typedef enum logic [1:0] {
    DQ_IDLE,
    DQ_ISSUE,
    DQ_ACK,
    DQ_BUSY
  } dma_q_state_e;

endpackage

// File: rtl/core_sync_fifo.sv
// Generic synchronous FIFO with registered occupancy count.
// Push into a full FIFO and pop from an empty one are ignored.
module core_sync_fifo
  import core_pkg::*;
#(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  T                           wdata,
  input  logic                       pop,
  output T                           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case (1'b1)
        (do_push && !do_pop): count <= count + 1'b1;
        (do_pop && !do_push): count <= count - 1'b1;
        default:              count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_dma_cmd_queue.sv
// Buffers EX-stage DMA commands and issues them one at a time
// to the PIM DMA engine, stalling the core only when full or fenced.
module core_dma_cmd_queue
  import core_pkg::*;
#(
  parameter int unsigned XLEN     = DMA_XLEN,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_PIM  = DMA_NUM_PIM,
  parameter int unsigned SIZE_W   = DMA_SIZE_W,
  parameter int unsigned ACK_WAIT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [2:0]                 cmd_funct3_i,
  input  logic [NUM_PIM-1:0]         cmd_sel_pim_i,
  input  logic [SIZE_W-1:0]          cmd_size_i,
  input  logic [XLEN-1:0]            cmd_addr_i,
  input  logic                       fence_i,
  output logic                       stall_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o,
  output logic                       dma_en_o,
  output logic [2:0]                 dma_funct3_o,
  output logic [NUM_PIM-1:0]         dma_sel_pim_o,
  output logic [SIZE_W-1:0]          dma_size_o,
  output logic [XLEN-1:0]            dma_mem_addr_o,
  input  logic                       dma_busy_i
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned TW = $clog2(ACK_WAIT+1);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_WAIT-1);

  typedef struct packed {
    logic [2:0]         funct3;
    logic [NUM_PIM-1:0] sel_pim;
    logic [SIZE_W-1:0]  size;
    logic [XLEN-1:0]    addr;
  } cmd_t;

  dma_q_state_e  state_q;
  dma_q_state_e  state_d;
  cmd_t          in_cmd;
  cmd_t          head;
  cmd_t          pay_q;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [TW-1:0] ack_q;
  logic [TW-1:0] ack_d;

  assign in_cmd = '{
    funct3:  cmd_funct3_i,
    sel_pim: cmd_sel_pim_i,
    size:    cmd_size_i,
    addr:    cmd_addr_i
  };

  // Zero-size transfers are acknowledged but never queued.
  assign cmd_ready_o = !full;
  assign push = cmd_valid_i && !full && (cmd_size_i != '0);

  core_sync_fifo #(
    .T     (cmd_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (in_cmd),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    pop     = 1'b0;
    unique case (state_q)
      DQ_IDLE: begin
        if (!empty && !dma_busy_i) begin
          pop     = 1'b1;
          state_d = DQ_ISSUE;
        end
      end
      DQ_ISSUE: begin
        ack_d   = '0;
        state_d = DQ_ACK;
      end
      DQ_ACK: begin
        if (dma_busy_i)             state_d = DQ_BUSY;
        else if (ack_q == ACK_LAST) state_d = DQ_IDLE;
        else                        ack_d   = ack_q + 1'b1;
      end
      DQ_BUSY: begin
        if (!dma_busy_i) state_d = DQ_IDLE;
      end
      default: state_d = DQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DQ_IDLE;
      ack_q   <= '0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      if (pop) pay_q <= head;
    end
  end

  assign dma_en_o       = (state_q == DQ_ISSUE);
  assign dma_funct3_o   = pay_q.funct3;
  assign dma_sel_pim_o  = pay_q.sel_pim;
  assign dma_size_o     = pay_q.size;
  assign dma_mem_addr_o = pay_q.addr;

  assign pending_o = count + CW'(state_q != DQ_IDLE);

  assign stall_o = (cmd_valid_i && !cmd_ready_o) ||
                   (fence_i && (pending_o != '0 || dma_busy_i));

endmodule

// File: tb/tb_core_dma_cmd_queue.sv
// Randomized scoreboard bench for the DMA command queue.
// A timing model of issue/ack/busy rules predicts every output.
module tb_core_dma_cmd_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [2:0]  cmd_funct3_i = '0;
  logic [3:0]  cmd_sel_pim_i = '0;
  logic [12:0] cmd_size_i = '0;
  logic [31:0] cmd_addr_i = '0;
  logic        fence_i = 1'b0;
  logic        stall_o;
  logic [2:0]  pending_o;
  logic        dma_en_o;
  logic [2:0]  dma_funct3_o;
  logic [3:0]  dma_sel_pim_o;
  logic [12:0] dma_size_o;
  logic [31:0] dma_mem_addr_o;
  logic        dma_busy_i = 1'b0;

  core_dma_cmd_queue #(
    .XLEN(32), .DEPTH(DEPTH), .NUM_PIM(4), .SIZE_W(13), .ACK_WAIT(AW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_funct3_i   (cmd_funct3_i),
    .cmd_sel_pim_i  (cmd_sel_pim_i),
    .cmd_size_i     (cmd_size_i),
    .cmd_addr_i     (cmd_addr_i),
    .fence_i        (fence_i),
    .stall_o        (stall_o),
    .pending_o      (pending_o),
    .dma_en_o       (dma_en_o),
    .dma_funct3_o   (dma_funct3_o),
    .dma_sel_pim_o  (dma_sel_pim_o),
    .dma_size_o     (dma_size_o),
    .dma_mem_addr_o (dma_mem_addr_o),
    .dma_busy_i     (dma_busy_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model state.
  logic [51:0] exp_q[$];
  logic [51:0] last_cmd = '0;
  bit          inflight = 0;
  bit          in_busy = 0;
  int          ack_left = 0;
  bit          exp_en_next = 0;
  bit          mon_on = 0;

  always @(negedge clk_i) begin
    if (mon_on) begin
      logic [51:0] got;
      logic [51:0] want;
      bit          rdy;
      bit          stl;
      bit          issued;
      int          pend;
      got = {dma_funct3_o, dma_sel_pim_o, dma_size_o, dma_mem_addr_o};
      issued = dma_en_o;
      chk("issue_timing", dma_en_o, exp_en_next);
      if (issued) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_empty actual=dma_en expected=no_issue");
        end else begin
          want = exp_q.pop_front();
          chk("payload_issue", got, want);
          last_cmd = want;
        end
        inflight = 1;
        in_busy  = 0;
        ack_left = AW;
      end else begin
        chk("payload_hold", got, last_cmd);
      end
      pend = exp_q.size() + int'(inflight);
      rdy  = exp_q.size() < DEPTH;
      stl  = (cmd_valid_i && !rdy) || (fence_i && (pend != 0 || dma_busy_i));
      chk("pending", pending_o, pend);
      chk("cmd_ready", cmd_ready_o, rdy);
      chk("stall", stall_o, stl);
      exp_en_next = !inflight && exp_q.size() > 0 && !dma_busy_i;
      if (!issued) begin
        if (inflight && !in_busy) begin
          if (dma_busy_i) in_busy = 1;
          else begin
            ack_left--;
            if (ack_left == 0) inflight = 0;
          end
        end else if (in_busy && !dma_busy_i) begin
          inflight = 0;
          in_busy  = 0;
        end
      end
      if (cmd_valid_i && rdy && cmd_size_i != 0)
        exp_q.push_back({cmd_funct3_i, cmd_sel_pim_i, cmd_size_i, cmd_addr_i});
    end
  end

  // DMA engine stand-in plus EX-stage command source.
  int rise = 0;
  int blen = 0;
  int ext = 0;
  int pend_len = 1;
  bit long_busy = 0;

  task automatic drive_cycle(input bit allow);
    @(posedge clk_i);
    #1;
    if (blen > 0) begin
      dma_busy_i = 1'b1;
      blen--;
    end else if (rise > 0) begin
      rise--;
      if (rise == 0) begin
        dma_busy_i = 1'b1;
        blen = pend_len - 1;
      end else dma_busy_i = 1'b0;
    end else if (ext > 0) begin
      dma_busy_i = 1'b1;
      ext--;
    end else begin
      dma_busy_i = 1'b0;
      if (!long_busy && $urandom_range(15) == 0) ext = $urandom_range(4, 1);
    end
    if (dma_en_o && (long_busy || $urandom_range(3) != 0)) begin
      rise = $urandom_range(2, 1);
      pend_len = long_busy ? 1000 : $urandom_range(6, 1);
    end
    cmd_valid_i   = allow && ($urandom_range(1) == 1);
    cmd_funct3_i  = 3'($urandom);
    cmd_sel_pim_i = 4'($urandom);
    cmd_size_i    = ($urandom_range(7) == 0) ? 13'd0 : 13'($urandom_range(8191, 1));
    cmd_addr_i    = $urandom;
    fence_i       = allow && ($urandom_range(9) == 0);
  endtask

  initial begin
    bit done;
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_en", dma_en_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_payload", {dma_funct3_o, dma_sel_pim_o, dma_size_o, dma_mem_addr_o}, 0);
    rst_ni = 1'b1;
    mon_on = 1;

    for (int i = 0; i < 3000; i++) drive_cycle(1);

    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      drive_cycle(0);
      if (exp_q.size() == 0 && !inflight) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain actual=not_drained expected=drained");
    end

    // Hold the engine busy with commands queued, then reset mid-flight.
    long_busy = 1;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      drive_cycle(1);
      cmd_valid_i = 1'b1;
      fence_i = 1'b0;
      if (cmd_size_i == 0) cmd_size_i = 13'd64;
      @(negedge clk_i);
      if (exp_q.size() >= 3 && in_busy) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fill_busy actual=not_reached expected=busy_with_3_queued");
    end
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    fence_i = 1'b0;
    #2;
    mon_on = 0;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_en", dma_en_o, 0);
    chk("mid_rst_pending", pending_o, 0);
    chk("mid_rst_ready", cmd_ready_o, 1);
    chk("mid_rst_payload", {dma_funct3_o, dma_sel_pim_o, dma_size_o, dma_mem_addr_o}, 0);
    dma_busy_i = 1'b0;
    blen = 0;
    rise = 0;
    ext = 0;
    chk("mid_rst_stall", stall_o, 0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("post_rst_en", dma_en_o, 0);
      chk("post_rst_pending", pending_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
